alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU operand interface (OPERAND1/OPERAND2/ALUOP -> ALURESULT).
//  - Accepts 32-bit instructions over a valid/ready handshake and decodes them.
//  - Reads source operands from an internal 8x8 register file and drives the ALU.
//  - Waits for the ALU to settle, then writes ALURESULT back to the destination register.
//  - One instruction in flight at a time; sits between instruction fetch and the alu.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/reg_file_8x8.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, ALU codes, FSM
// state encodings, instruction field positions and the decoded-instruction layout.
package alu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  localparam int FLD_W    = 8;
  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

  // 8-bit two's complement negation; -(-128) wraps back to -128.
  function automatic logic [7:0] neg8(input logic [7:0] v);
    return (~v) + 8'd1;
  endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// Eight 8-bit registers with two combinational read ports, a debug read port
// and one synchronous write port; all registers reset asynchronously to zero.
module reg_file_8x8 (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       WRITEENABLE,
  input  logic [2:0] ADDR,
  input  logic [7:0] DATA,
  input  logic [2:0] RADDR1,
  output logic [7:0] RDATA1,
  input  logic [2:0] RADDR2,
  output logic [7:0] RDATA2,
  input  logic [2:0] DBG_ADDR,
  output logic [7:0] DBG_DATA
);

  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];

  always_comb begin
    regs_d = regs_q;
    if (WRITEENABLE) begin
      regs_d[ADDR] = DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign RDATA1   = regs_q[RADDR1];
  assign RDATA2   = regs_q[RADDR2];
  assign DBG_DATA = regs_q[DBG_ADDR];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external ALU: decode, operand fetch,
// ALU settle wait, then write-back of ALURESULT into the internal register file.
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter int ALU_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [7:0]  OPERAND1,
  output logic [7:0]  OPERAND2,
  output logic [2:0]  ALUOP,
  input  logic [7:0]  ALURESULT,
  output logic        DONE,
  output logic        ERR,
  output logic        BUSY,
  input  logic [2:0]  DBG_ADDR,
  output logic [7:0]  DBG_DATA
);

  localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

  logic [1:0] state_q, state_d;
  instr_t     instr_q, instr_d;
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic [2:0] aluop_q, aluop_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] wait_q, wait_d;

  logic [7:0] rd1_dat;
  logic [7:0] rd2_dat;
  logic       illegal;
  logic       wb_en;

  reg_file_8x8 u_rf (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .WRITEENABLE (wb_en),
    .ADDR        (instr_q.dest[2:0]),
    .DATA        (ALURESULT),
    .RADDR1      (instr_q.src1[2:0]),
    .RDATA1      (rd1_dat),
    .RADDR2      (instr_q.src2[2:0]),
    .RDATA2      (rd2_dat),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_DATA    (DBG_DATA)
  );

  // loadi carries an immediate in the src2 field, so its upper bits are not an address.
  always_comb begin
    illegal = (instr_q.opcode > OP_OR)
           || (instr_q.dest[7:3] != 5'd0)
           || (instr_q.src1[7:3] != 5'd0)
           || ((instr_q.opcode != OP_LOADI) && (instr_q.src2[7:3] != 5'd0));
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    aluop_d = aluop_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wb_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          instr_d.opcode = INSTR[OPC_LSB  +: FLD_W];
          instr_d.dest   = INSTR[DST_LSB  +: FLD_W];
          instr_d.src1   = INSTR[SRC1_LSB +: FLD_W];
          instr_d.src2   = INSTR[SRC2_LSB +: FLD_W];
          state_d        = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (illegal) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          case (instr_q.opcode)
            OP_LOADI: begin
              op1_d   = 8'd0;
              op2_d   = instr_q.src2;
              aluop_d = ALU_FWD;
            end
            OP_MOV: begin
              op1_d   = 8'd0;
              op2_d   = rd2_dat;
              aluop_d = ALU_FWD;
            end
            OP_ADD: begin
              op1_d   = rd1_dat;
              op2_d   = rd2_dat;
              aluop_d = ALU_ADD;
            end
            OP_SUB: begin
              op1_d   = rd1_dat;
              op2_d   = neg8(rd2_dat);
              aluop_d = ALU_ADD;
            end
            OP_AND: begin
              op1_d   = rd1_dat;
              op2_d   = rd2_dat;
              aluop_d = ALU_AND;
            end
            default: begin
              op1_d   = rd1_dat;
              op2_d   = rd2_dat;
              aluop_d = ALU_OR;
            end
          endcase
          wait_d  = WAIT_LOAD;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (wait_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = ST_WB;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_WB: begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      op1_q   <= 8'd0;
      op2_q   <= 8'd0;
      aluop_q <= ALU_FWD;
      wait_q  <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      aluop_q <= aluop_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign INSTR_READY = (state_q == ST_IDLE) && RESET_N;
  assign BUSY        = (state_q != ST_IDLE);
  assign OPERAND1    = op1_q;
  assign OPERAND2    = op2_q;
  assign ALUOP       = aluop_q;
  assign DONE        = done_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl at ALU_WAIT=1 and 3: an ALU model closes the loop and a
// transaction-timeline model predicts every output on each falling edge.
module tb_alu_issue_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 instruction, 1 reset during EXEC, 2 reg literal, 3 operand literal
    logic [31:0] w;
    int          addr;
    int          v1;
    int          v2;
    int          v3;
  } item_t;

  task automatic chk(input string name, input int w, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (ALU_WAIT=%0d): got %0d, expected %0d", name, w, act, exp);
    end
  endtask

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return b;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return 8'd0;
    endcase
  endfunction

  function automatic item_t mk_i(input logic [7:0] op, input logic [7:0] d, input logic [7:0] s1, input logic [7:0] s2);
    item_t it;
    it.kind = 0; it.w = {op, d, s1, s2}; it.addr = 0; it.v1 = 0; it.v2 = 0; it.v3 = 0;
    return it;
  endfunction

  function automatic item_t mk_k(input int kind, input int addr, input int v1, input int v2, input int v3);
    item_t it;
    it.kind = kind; it.w = 32'd0; it.addr = addr; it.v1 = v1; it.v2 = v2; it.v3 = v3;
    return it;
  endfunction

  function automatic logic [7:0] rnd_fld();
    if ($urandom_range(0, 11) == 0) return 8'($urandom_range(8, 255));
    return 8'($urandom_range(0, 7));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int W = (g == 0) ? 1 : 3;

    logic        RESET_N;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [7:0]  OPERAND1;
    logic [7:0]  OPERAND2;
    logic [2:0]  ALUOP;
    logic [7:0]  ALURESULT;
    logic        DONE;
    logic        ERR;
    logic        BUSY;
    logic [2:0]  DBG_ADDR;
    logic [7:0]  DBG_DATA;
    bit          fin = 1'b0;

    alu_issue_ctrl #(.ALU_WAIT(W)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .INSTR       (INSTR),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .OPERAND1    (OPERAND1),
      .OPERAND2    (OPERAND2),
      .ALUOP       (ALUOP),
      .ALURESULT   (ALURESULT),
      .DONE        (DONE),
      .ERR         (ERR),
      .BUSY        (BUSY),
      .DBG_ADDR    (DBG_ADDR),
      .DBG_DATA    (DBG_DATA)
    );

    always_comb ALURESULT = alu_fn(ALUOP, OPERAND1, OPERAND2);

    item_t      q[$];
    logic [7:0] mregs [8];
    logic [7:0] mop1, mop2, e1, e2, mres, va, vb;
    logic [7:0] p_op, p_d, p_s1, p_s2;
    logic [2:0] maluop, ea, mdst, dbg_a;
    bit         have, lg, busy_e, ready_e, running;
    int         a, rst_cnt;
    item_t      it;

    initial begin
      RESET_N = 1'b0; INSTR = 32'd0; INSTR_VALID = 1'b0; DBG_ADDR = 3'd0;

      q.push_back(mk_i(8'h00, 8'd1, 8'd0, 8'd45));
      q.push_back(mk_i(8'h00, 8'd2, 8'd0, 8'd30));
      q.push_back(mk_i(8'h02, 8'd3, 8'd1, 8'd2));
      q.push_back(mk_k(3, 0, 45, 30, 1));
      q.push_back(mk_k(2, 3, 75, 0, 0));
      q.push_back(mk_i(8'h03, 8'd6, 8'd1, 8'd2));
      q.push_back(mk_k(3, 0, 45, 8'hE2, 1));
      q.push_back(mk_k(2, 6, 15, 0, 0));
      q.push_back(mk_i(8'h01, 8'd7, 8'd0, 8'd3));
      q.push_back(mk_k(3, 0, 0, 75, 0));
      q.push_back(mk_k(2, 7, 75, 0, 0));
      q.push_back(mk_i(8'h00, 8'd1, 8'd0, 8'h26));
      q.push_back(mk_i(8'h00, 8'd2, 8'd0, 8'h3A));
      q.push_back(mk_i(8'h04, 8'd4, 8'd1, 8'd2));
      q.push_back(mk_k(3, 0, 8'h26, 8'h3A, 2));
      q.push_back(mk_k(2, 4, 8'h22, 0, 0));
      q.push_back(mk_i(8'h05, 8'd5, 8'd1, 8'd2));
      q.push_back(mk_k(3, 0, 8'h26, 8'h3A, 3));
      q.push_back(mk_k(2, 5, 8'h3E, 0, 0));
      q.push_back(mk_i(8'h00, 8'd1, 8'd0, 8'h80));
      q.push_back(mk_i(8'h00, 8'd2, 8'd0, 8'h01));
      q.push_back(mk_i(8'h03, 8'd6, 8'd1, 8'd2));
      q.push_back(mk_k(3, 0, 8'h80, 8'hFF, 1));
      q.push_back(mk_k(2, 6, 8'h7F, 0, 0));
      q.push_back(mk_i(8'h07, 8'd1, 8'd1, 8'd2));
      q.push_back(mk_i(8'h02, 8'd8, 8'd1, 8'd2));
      q.push_back(mk_i(8'h02, 8'd3, 8'd1, 8'd9));
      q.push_back(mk_k(2, 1, 8'h80, 0, 0));
      q.push_back(mk_k(2, 3, 75, 0, 0));
      q.push_back(mk_k(3, 0, 8'h80, 8'hFF, 1));
      q.push_back(mk_i(8'h00, 8'd2, 8'd0, 8'h80));
      q.push_back(mk_i(8'h03, 8'd6, 8'd1, 8'd2));
      q.push_back(mk_k(3, 0, 8'h80, 8'h80, 1));
      q.push_back(mk_k(2, 6, 0, 0, 0));
      q.push_back(mk_i(8'h02, 8'd1, 8'd1, 8'd1));
      q.push_back(mk_k(2, 1, 0, 0, 0));
      q.push_back(mk_i(8'h02, 8'd3, 8'd1, 8'd2));
      q.push_back(mk_k(1, 0, 0, 0, 0));
      q.push_back(mk_k(2, 3, 0, 0, 0));
      q.push_back(mk_k(2, 2, 0, 0, 0));
      q.push_back(mk_k(3, 0, 0, 0, 0));
      for (int i = 0; i < 60; i++) begin
        logic [7:0] rop;
        rop = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
        q.push_back(mk_i(rop, rnd_fld(), rnd_fld(), (rop == 8'h00) ? 8'($urandom) : rnd_fld()));
      end

      for (int i = 0; i < 8; i++) begin
        DBG_ADDR = 3'(i);
        @(negedge CLK);
        chk("reset_dbg_data", W, int'(DBG_DATA), 0);
        if (i == 0) begin
          chk("reset_ready", W, int'(INSTR_READY), 0);
          chk("reset_busy", W, int'(BUSY), 0);
          chk("reset_done", W, int'(DONE), 0);
          chk("reset_err", W, int'(ERR), 0);
          chk("reset_operand1", W, int'(OPERAND1), 0);
          chk("reset_operand2", W, int'(OPERAND2), 0);
          chk("reset_aluop", W, int'(ALUOP), 0);
        end
      end
      RESET_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
      mop1 = 8'd0; mop2 = 8'd0; maluop = 3'd0;
      have = 1'b0; lg = 1'b0; a = 0; rst_cnt = 0; running = 1'b1;
      mdst = 3'd0; mres = 8'd0; e1 = 8'd0; e2 = 8'd0; ea = 3'd0;
      dbg_a = DBG_ADDR;

      while (running) begin
        @(negedge CLK);
        if (have && lg && cyc == a + 1) begin
          mop1 = e1; mop2 = e2; maluop = ea;
        end
        if (have && lg && cyc == a + W + 2) mregs[mdst] = mres;
        busy_e  = have && (cyc >= a) && (cyc <= (lg ? a + W + 1 : a));
        ready_e = RESET_N && !busy_e;

        chk("busy", W, int'(BUSY), int'(busy_e));
        chk("instr_ready", W, int'(INSTR_READY), int'(ready_e));
        chk("done", W, int'(DONE), int'(have && lg && cyc == a + W + 1));
        chk("err", W, int'(ERR), int'(have && !lg && cyc == a + 1));
        chk("operand1", W, int'(OPERAND1), int'(mop1));
        chk("operand2", W, int'(OPERAND2), int'(mop2));
        chk("aluop", W, int'(ALUOP), int'(maluop));
        chk("dbg_data", W, int'(DBG_DATA), int'(mregs[dbg_a]));

        DBG_ADDR = 3'($urandom_range(0, 7));
        dbg_a    = DBG_ADDR;

        if (rst_cnt > 0) begin
          rst_cnt--;
          if (rst_cnt == 0) RESET_N = 1'b1;
          INSTR_VALID = 1'($urandom_range(0, 1));
          INSTR       = $urandom;
        end else if (ready_e) begin
          while (q.size() > 0 && q[0].kind != 0) begin
            it = q.pop_front();
            if (it.kind == 2) begin
              chk("model_reg_literal", W, int'(mregs[it.addr[2:0]]), it.v1);
            end else if (it.kind == 3) begin
              chk("model_op1_literal", W, int'(mop1), it.v1);
              chk("model_op2_literal", W, int'(mop2), it.v2);
              chk("model_aluop_literal", W, int'(maluop), it.v3);
            end
          end
          if (q.size() == 0) begin
            running     = 1'b0;
            INSTR_VALID = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            INSTR_VALID = 1'b0;
            INSTR       = $urandom;
          end else begin
            it = q.pop_front();
            INSTR       = it.w;
            INSTR_VALID = 1'b1;
            {p_op, p_d, p_s1, p_s2} = it.w;
            lg   = (p_op <= 8'd5) && (p_d < 8'd8) && (p_s1 < 8'd8) && (p_op == 8'd0 || p_s2 < 8'd8);
            va   = mregs[p_s1[2:0]];
            vb   = mregs[p_s2[2:0]];
            mdst = p_d[2:0];
            case (p_op)
              8'd0:    begin e1 = 8'd0; e2 = p_s2;        ea = 3'd0; mres = p_s2;    end
              8'd1:    begin e1 = 8'd0; e2 = vb;          ea = 3'd0; mres = vb;      end
              8'd2:    begin e1 = va;   e2 = vb;          ea = 3'd1; mres = va + vb; end
              8'd3:    begin e1 = va;   e2 = 8'd0 - vb;   ea = 3'd1; mres = va - vb; end
              8'd4:    begin e1 = va;   e2 = vb;          ea = 3'd2; mres = va & vb; end
              8'd5:    begin e1 = va;   e2 = vb;          ea = 3'd3; mres = va | vb; end
              default: begin e1 = 8'd0; e2 = 8'd0;        ea = 3'd0; mres = 8'd0;    end
            endcase
            a    = cyc + 1;
            have = 1'b1;
          end
        end else begin
          if (q.size() > 0 && q[0].kind == 1 && have && lg && cyc == a + 1) begin
            it = q.pop_front();
            RESET_N = 1'b0;
            rst_cnt = 2;
            have    = 1'b0;
            for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
            mop1 = 8'd0; mop2 = 8'd0; maluop = 3'd0;
          end
          INSTR_VALID = 1'($urandom_range(0, 1));
          INSTR       = $urandom;
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(inst[0].fin && inst[1].fin) && n < 20000) begin
      @(posedge CLK);
      n++;
    end
    if (!(inst[0].fin && inst[1].fin)) begin
      checks++;
      errors++;
      $display("FAIL watchdog: stimulus still running after %0d cycles, expected completion", n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
